// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver for a 64x32, 1/16-scan panel with 5-plane binary-code modulation.
// Reads one top/bottom RGB565 pixel pair per column from the frame buffer and shifts it out.
module hub75_scan_driver #(
    parameter int BITS_PER_PIXEL = 16,
    parameter int BASE_TIME      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    output logic [9:0]                read_addr,
    output logic                      read_en,
    input  logic [BITS_PER_PIXEL-1:0] read_data_top,
    input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
    output logic                      r1,
    output logic                      g1,
    output logic                      b1,
    output logic                      r2,
    output logic                      g2,
    output logic                      b2,
    output logic                      pclk,
    output logic                      lat,
    output logic                      oe_n,
    output logic [3:0]                row_addr,
    output logic                      frame_done,
    output logic [2:0]                state_dbg
);

    localparam int DISP_W = $clog2(BASE_TIME * 16);
    localparam int IW     = $clog2(BITS_PER_PIXEL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_TAIL    = 3'd2,
        S_LATCH   = 3'd3,
        S_DISPLAY = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          row_q, row_d;
    logic [2:0]          plane_q, plane_d;
    logic [5:0]          col_q, col_d;
    logic                phase_q, phase_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic [9:0]          read_addr_q, read_addr_d;
    logic                read_en_q, read_en_d;
    logic [5:0]          rgb_q, rgb_d;
    logic                pclk_q, pclk_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic [3:0]          row_addr_q, row_addr_d;
    logic                frame_done_q, frame_done_d;
    logic                start_shift;
    logic [DISP_W-1:0]   disp_last;
    logic [IW-1:0]       r_idx, g_idx, b_idx;

    assign disp_last = DISP_W'((BASE_TIME << plane_q) - 1);
    // Green LSB (data[5]) is dropped so all three colours use 5 planes.
    assign r_idx = IW'(11) + IW'(plane_q);
    assign g_idx = IW'(6) + IW'(plane_q);
    assign b_idx = IW'(plane_q);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        col_d        = col_q;
        phase_d      = phase_q;
        disp_d       = disp_q;
        read_addr_d  = read_addr_q;
        read_en_d    = 1'b0;
        rgb_d        = rgb_q;
        pclk_d       = 1'b0;
        lat_d        = 1'b0;
        oe_n_d       = 1'b1;
        row_addr_d   = row_addr_q;
        frame_done_d = 1'b0;
        start_shift  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    row_d       = 4'd0;
                    plane_d     = 3'd0;
                    start_shift = 1'b1;
                end
            end
            S_SHIFT: begin
                read_en_d = 1'b1;
                if (!phase_q) begin
                    phase_d = 1'b1;
                    pclk_d  = (col_q != 6'd0);
                end else begin
                    phase_d = 1'b0;
                    rgb_d   = {read_data_top[r_idx], read_data_top[g_idx], read_data_top[b_idx],
                               read_data_bottom[r_idx], read_data_bottom[g_idx], read_data_bottom[b_idx]};
                    if (col_q == 6'd63) begin
                        read_en_d = 1'b0;
                        state_d   = S_TAIL;
                    end else begin
                        col_d       = col_q + 6'd1;
                        read_addr_d = {row_q, col_q + 6'd1};
                    end
                end
            end
            // Rising edge for column 63 lands here so its data has a full cycle of setup.
            S_TAIL: begin
                pclk_d  = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                lat_d      = 1'b1;
                row_addr_d = row_q;
                disp_d     = '0;
                state_d    = S_DISPLAY;
            end
            S_DISPLAY: begin
                oe_n_d = 1'b0;
                disp_d = disp_q + 1'b1;
                if (disp_q == disp_last) begin
                    if (plane_q != 3'd4) begin
                        plane_d     = plane_q + 3'd1;
                        start_shift = 1'b1;
                    end else begin
                        plane_d = 3'd0;
                        if (row_q == 4'd15) begin
                            frame_done_d = 1'b1;
                            row_d        = 4'd0;
                            start_shift  = enable;
                            if (!enable) state_d = S_IDLE;
                        end else begin
                            row_d       = row_q + 4'd1;
                            start_shift = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start_shift) begin
            state_d     = S_SHIFT;
            col_d       = 6'd0;
            phase_d     = 1'b0;
            read_en_d   = 1'b1;
            read_addr_d = {row_d, 6'd0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            disp_q       <= '0;
            read_addr_q  <= '0;
            read_en_q    <= 1'b0;
            rgb_q        <= '0;
            pclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            disp_q       <= disp_d;
            read_addr_q  <= read_addr_d;
            read_en_q    <= read_en_d;
            rgb_q        <= rgb_d;
            pclk_q       <= pclk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            row_addr_q   <= row_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign read_addr              = read_addr_q;
    assign read_en                = read_en_q;
    assign {r1, g1, b1, r2, g2, b2} = rgb_q;
    assign pclk                   = pclk_q;
    assign lat                    = lat_q;
    assign oe_n                   = oe_n_q;
    assign row_addr               = row_addr_q;
    assign frame_done             = frame_done_q;
    assign state_dbg              = state_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: frame-timeline model checked every cycle, plus literal
// expectations for edge counts, oe_n durations, pixel positions, frame length and reset.
module tb_hub75_scan_driver;

    localparam int BT    = 8;
    localparam int ROWP  = 898;
    localparam int FRAME = 14368;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [15:0] read_data_top, read_data_bottom;
    logic        r1, g1, b1, r2, g2, b2;
    logic        pclk, lat, oe_n;
    logic [3:0]  row_addr;
    logic        frame_done;
    logic [2:0]  state_dbg;

    logic [15:0] top_mem [1024];
    logic [15:0] bot_mem [1024];

    hub75_scan_driver #(.BITS_PER_PIXEL(16), .BASE_TIME(BT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .read_addr(read_addr), .read_en(read_en),
        .read_data_top(read_data_top), .read_data_bottom(read_data_bottom),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .pclk(pclk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // frame buffer read port: one cycle of latency, all-ones when not enabled
    always @(posedge clk) begin
        if (read_en) begin
            read_data_top    <= top_mem[read_addr];
            read_data_bottom <= bot_mem[read_addr];
        end else begin
            read_data_top    <= 16'hFFFF;
            read_data_bottom <= 16'hFFFF;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [9:0] addr;
        logic       ren;
        logic [5:0] rgb;
        logic       pclk;
        logic       lat;
        logic       oe_n;
        logic [3:0] row_addr;
        logic       fd;
    } outs_t;

    logic idle_after = 1'b0;

    // Position within the frame timeline: row, plane and cycle offset inside that plane.
    function automatic void pos(input int n, output int row, output int plane, output int t);
        int f, r, per;
        f = n % FRAME;
        row = f / ROWP;
        r = f % ROWP;
        plane = 0;
        per = 130 + BT;
        while (r >= per) begin
            r -= per;
            plane++;
            per = 130 + (BT << plane);
        end
        t = r;
    endfunction

    function automatic logic [5:0] pix_bits(input int row, input int plane, input int col);
        logic [15:0] tp, bp;
        tp = top_mem[row * 64 + col];
        bp = bot_mem[row * 64 + col];
        return {1'(tp >> (11 + plane)), 1'(tp >> (6 + plane)), 1'(tp >> plane),
                1'(bp >> (11 + plane)), 1'(bp >> (6 + plane)), 1'(bp >> plane)};
    endfunction

    function automatic outs_t expect_at(input int n);
        outs_t e;
        int row, pl, t, prow, ppl, pt, col;
        if (idle_after && n >= FRAME) begin
            e.addr = 10'd0; e.ren = 1'b0; e.rgb = pix_bits(15, 4, 63);
            e.pclk = 1'b0; e.lat = 1'b0; e.oe_n = (n != FRAME);
            e.row_addr = 4'd15; e.fd = (n == FRAME);
            return e;
        end
        pos(n, row, pl, t);
        e.ren  = (t < 128);
        e.addr = e.ren ? 10'(row * 64 + t / 2) : 10'd0;
        e.pclk = (t >= 3 && t <= 127 && (t % 2) == 1) || (t == 129);
        e.lat  = (t == 130);
        if (n == 0) e.oe_n = 1'b1;
        else begin
            pos(n - 1, prow, ppl, pt);
            e.oe_n = !(pt >= 130);
        end
        if (t >= 2) begin
            col = (t - 2) / 2;
            if (col > 63) col = 63;
            e.rgb = pix_bits(row, pl, col);
        end else if (n > t) begin
            pos(n - t - 1, prow, ppl, pt);
            e.rgb = pix_bits(prow, ppl, 63);
        end else e.rgb = 6'd0;
        if (t >= 130) e.row_addr = 4'(row);
        else if (n > t) begin
            pos(n - t - 1, prow, ppl, pt);
            e.row_addr = 4'(prow);
        end else e.row_addr = 4'd0;
        e.fd = (n > 0) && (n % FRAME == 0);
        return e;
    endfunction

    // ---------------- compare process + statistics ----------------
    logic  model_on = 1'b0;
    logic  stats_on = 1'b0;
    int    n = 0;
    outs_t exp_v, act_v;
    logic  pclk_prev, lat_seen;
    logic [3:0] row_addr_prev;
    int    edge_idx, plane0_rises, plane0_lats, gb1_cycles, oe_run, fd_count, fd_n, rowchg_bad;
    int    oe_runs[$];
    int    r1_hits[$];
    int    g2_hits[$];
    int    b2_hits[$];

    always @(negedge clk) begin
        if (!model_on) n = 0;
        else begin
            exp_v = expect_at(n);
            act_v.addr = exp_v.ren ? read_addr : 10'd0;
            act_v.ren = read_en;
            act_v.rgb = {r1, g1, b1, r2, g2, b2};
            act_v.pclk = pclk;
            act_v.lat = lat;
            act_v.oe_n = oe_n;
            act_v.row_addr = row_addr;
            act_v.fd = frame_done;
            check($sformatf("cycle%0d", n), 32'(act_v), 32'(exp_v));
            if (n == 0) begin
                check("first_read_addr", 32'(read_addr), 32'h000);
                check("first_read_en", 32'(read_en), 32'd1);
                pclk_prev = 1'b0;
                row_addr_prev = row_addr;
                edge_idx = 0;
            end
            if (stats_on) begin
                if (lat) edge_idx = 0;
                if (pclk && !pclk_prev) begin
                    edge_idx++;
                    if (n < 138) plane0_rises++;
                    if (r1) r1_hits.push_back(edge_idx);
                    if (g2) g2_hits.push_back(edge_idx);
                    if (b2) b2_hits.push_back(edge_idx);
                end
                if (lat && n < 138) plane0_lats++;
                if (g1 || b1) gb1_cycles++;
                if (!oe_n) oe_run++;
                else if (oe_run > 0) begin
                    oe_runs.push_back(oe_run);
                    oe_run = 0;
                end
                if (frame_done) begin
                    fd_count++;
                    fd_n = n;
                end
                if (row_addr != row_addr_prev && !lat) rowchg_bad++;
                if (lat && oe_n == 1'b0) rowchg_bad++;
            end
            pclk_prev = pclk;
            row_addr_prev = row_addr;
            n++;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_read_addr"}, 32'(read_addr), 32'h0);
        check({tag, "_read_en"}, 32'(read_en), 32'd0);
        check({tag, "_rgb"}, 32'({r1, g1, b1, r2, g2, b2}), 32'h0);
        check({tag, "_pclk"}, 32'(pclk), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd0);
        check({tag, "_oe_n"}, 32'(oe_n), 32'd1);
        check({tag, "_row_addr"}, 32'(row_addr), 32'h0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        lat_seen = 1'b0;
        plane0_rises = 0; plane0_lats = 0; gb1_cycles = 0; oe_run = 0;
        fd_count = 0; fd_n = -1; rowchg_bad = 0; edge_idx = 0;
        for (int i = 0; i < 1024; i++) begin
            top_mem[i] = 16'h0000;
            bot_mem[i] = 16'h0000;
        end
        top_mem[0 * 64 + 5]  = 16'hF800;
        bot_mem[3 * 64 + 63] = 16'h07E0;
        bot_mem[5 * 64 + 10] = 16'h0020;
        bot_mem[9 * 64 + 0]  = 16'h001F;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // one full frame, enable dropped in row 7
        @(negedge clk);
        enable = 1'b1;
        idle_after = 1'b1;
        stats_on = 1'b1;
        @(posedge clk);
        model_on = 1'b1;
        repeat (7 * ROWP + 100) @(posedge clk);
        enable = 1'b0;
        repeat (FRAME + 60 - (7 * ROWP + 100)) @(posedge clk);
        model_on = 1'b0;
        stats_on = 1'b0;
        #1;
        check("idle_read_en", 32'(read_en), 32'd0);
        check("idle_oe_n", 32'(oe_n), 32'd1);
        check("idle_pclk", 32'(pclk), 32'd0);
        check("plane0_pclk_rises", 32'(plane0_rises), 32'd64);
        check("plane0_lat_pulses", 32'(plane0_lats), 32'd1);
        check("oe_low_runs", 32'(oe_runs.size()), 32'd80);
        if (oe_runs.size() >= 5) begin
            check("oe_low_plane0", 32'(oe_runs[0]), 32'd8);
            check("oe_low_plane1", 32'(oe_runs[1]), 32'd16);
            check("oe_low_plane2", 32'(oe_runs[2]), 32'd32);
            check("oe_low_plane3", 32'(oe_runs[3]), 32'd64);
            check("oe_low_plane4", 32'(oe_runs[4]), 32'd128);
        end
        check("r1_hit_count", 32'(r1_hits.size()), 32'd5);
        foreach (r1_hits[i]) check("r1_hit_edge", 32'(r1_hits[i]), 32'd6);
        check("g2_hit_count", 32'(g2_hits.size()), 32'd5);
        foreach (g2_hits[i]) check("g2_hit_edge", 32'(g2_hits[i]), 32'd64);
        check("b2_hit_count", 32'(b2_hits.size()), 32'd5);
        foreach (b2_hits[i]) check("b2_hit_edge", 32'(b2_hits[i]), 32'd1);
        check("g1_b1_high_cycles", 32'(gb1_cycles), 32'd0);
        check("frame_done_count", 32'(fd_count), 32'd1);
        check("frame_done_cycle", 32'(fd_n), 32'(FRAME));
        check("row_addr_lat_rules", 32'(rowchg_bad), 32'd0);

        // clean restart, then reset during DISPLAY of row 0 plane 1
        @(negedge clk);
        rst_n = 1'b0;
        idle_after = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        model_on = 1'b1;
        repeat (278) @(posedge clk);
        model_on = 1'b0;
        #1;
        check("display_oe_n_low", 32'(oe_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_oe_n", 32'(oe_n), 32'd1);
        check("mid_reset_pclk", 32'(pclk), 32'd0);
        check("mid_reset_lat", 32'(lat), 32'd0);
        check_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_on = 1'b1;
        repeat (300) @(posedge clk);
        model_on = 1'b0;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Scan driver that reads the panel's dual-port frame buffer and drives a 64x32, 1/16-scan HUB75 panel. Each cycle it reads one top-half and one bottom-half RGB565 pixel and shifts 64 columns per bit plane. It latches the row, then shows each plane for a binary-weighted time (5-plane binary-code modulation). It is the consumer on the buffer's read port and issues the frame-done pulse that upstream logic uses to flip the buffer toggle.

## Interface
- BITS_PER_PIXEL, 16, pixel width; RGB565 layout R=[15:11], G=[10:5], B=[4:0].
- BASE_TIME, 8, clk cycles of `oe_n` low for plane 0; plane b shows BASE_TIME<<b cycles.

- clk  in  1  single clock (buffer read clock).
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  start or continue scanning frames.
- read_addr  out  10  buffer read address {row[3:0], col[5:0]}.
- read_en  out  1  buffer read enable.
- read_data_top  in  16  pixel for panel row `row`, valid 1 clk after the address.
- read_data_bottom  in  16  pixel for panel row `row`+16, same timing.
- r1, g1, b1, r2, g2, b2  out  1 each  panel serial data, top (1) and bottom (2) half.
- pclk  out  1  panel shift clock.
- lat  out  1  panel latch, active high.
- oe_n  out  1  panel output enable, active low.
- row_addr  out  4  panel A–D row select.
- frame_done  out  1  one-cycle pulse at the end of each complete frame.

## Operation
- States are IDLE, SHIFT, TAIL, LATCH and DISPLAY. Counters are row (0–15), plane (0–4), col (0–63), phase (0/1) and disp (wide enough for BASE_TIME<<4).
- IDLE: `oe_n`=1, `read_en`=0. Move to SHIFT with row=0, plane=0 when `enable`=1.
- SHIFT takes 128 cycles, two per column c:
  - Phase 0: `read_addr`={row,c}, `read_en`=1. At the closing edge, `pclk`<=1 if c>0, which clocks in column c−1.
  - Phase 1: data is valid. At the closing edge, the rgb outputs take plane bits of column c and `pclk`<=0.
  - Plane bits for plane b: R=data[11+b], G=data[6+b] (LSB of green dropped), B=data[b]. Top-half data drives r1/g1/b1; bottom-half data drives r2/g2/b2.
- TAIL: 1 cycle. `pclk`<=1, clocking in column 63. `read_en`=0.
- LATCH: 1 cycle with `lat`=1, `pclk`=0, `oe_n`=1. `row_addr` updates to row at this edge, while the panel is blanked.
- DISPLAY: `oe_n`=0 for exactly BASE_TIME<<plane cycles, then `oe_n`<=1.
  - If plane<4: plane+1, back to SHIFT.
  - Else plane=0, row+1, back to SHIFT.
  - After row 15, plane 4: pulse `frame_done`, wrap row to 0. Continue to SHIFT if `enable`=1, otherwise go to IDLE.
- `enable` is sampled only in IDLE and at frame end. Deasserting it mid-frame finishes the current frame.
- Outside SHIFT, `read_en`=0. The buffer's all-ones output in that case is ignored.

## Timing
- All outputs are registered. Reset values: `read_addr`=0, `read_en`=0, rgb=0, `pclk`=0, `lat`=0, `oe_n`=1, `row_addr`=0, `frame_done`=0, state IDLE.
- Read latency is 1 clk; the driver never uses data in the same cycle the address is issued.
- Per plane: exactly 64 `pclk` rising edges. Each rising edge has rgb stable ≥1 clk before and after.
- `pclk` high and low phases are each 1 clk.
- `lat` is high exactly 1 clk, with `oe_n`=1 and `pclk`=0. `lat` and `oe_n`=0 are never asserted together.
- Plane period = 130 + BASE_TIME<<b cycles. With BASE_TIME=8, one row = 650 + 248 = 898 cycles and one frame = 14368 cycles.
- Asserting reset mid-operation forces the reset values immediately; the panel blanks through `oe_n`=1.

## Test plan
- Reset, then `enable`=1 with a buffer model of 1-cycle latency: first `read_addr`=0x000 with `read_en`=1 the cycle after leaving IDLE. Count 64 `pclk` rising edges, then one `lat` pulse, then `oe_n` low for 8 cycles.
- Top pixel (row 0, col 5) = 0xF800, all others 0: r1=1 only at the 6th `pclk` edge in planes 0–4; g1 and b1 are never 1.
- Bottom pixel (row 3, col 63) = 0x07E0: g2=1 at the 64th edge of row 3 for all planes. Green bit 5 (data[5]) alone gives g2=0 in every plane.
- Over one row, `oe_n` low durations are 8, 16, 32, 64, 128. `row_addr` changes only in a cycle where `lat`=1.
- Drop `enable` in row 7: the frame completes through row 15, plane 4. `frame_done` pulses exactly once, 14368 cycles after the start, and the FSM sits in IDLE with `oe_n`=1.
- Assert `rst_n`=0 during DISPLAY: the same cycle gives `oe_n`=1, `pclk`=0, `lat`=0. Release and enable: the scan restarts at row 0, plane 0.
